// File: rtl/write_control.sv
// write_control: write side of the event-package ring buffer.
// Each accepted trigger streams one package of PACKAGE_LENGTH words into the
// shared memory at consecutive (wrapping) addresses. All 16 channels share
// the same write enable and address. A read_start pulse follows every complete
// package. Packages that have been stored but not yet read are counted so
// that unread data is never overwritten. Rejected triggers are counted.
module write_control #(
    parameter int PACKAGE_LENGTH = 518,
    parameter int MEMORY_DEPTH   = 24576,
    parameter int MAX_PACKAGES   = 47
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        live_rising,
    input  logic        trigger,
    input  logic        read_done,
    output logic        wen,
    output logic [14:0] waddr,
    output logic        read_start,
    output logic        busy,
    output logic [5:0]  n_stored,
    output logic [15:0] n_lost
);

    localparam logic [15:0] DEPTH16   = 16'(MEMORY_DEPTH);
    localparam logic [15:0] PKG_LEN16 = 16'(PACKAGE_LENGTH);
    localparam logic [11:0] LAST_CNT  = 12'(PACKAGE_LENGTH - 1);
    localparam logic [5:0]  MAX_PKG   = 6'(MAX_PACKAGES);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t      state_reg,      state_next;
    logic        wen_reg,        wen_next;
    logic [14:0] waddr_reg,      waddr_next;
    logic [11:0] cnt_reg,        cnt_next;
    logic [14:0] wptr_reg,       wptr_next;
    logic        read_start_reg, read_start_next;
    logic [5:0]  n_stored_reg,   n_stored_next;
    logic [15:0] n_lost_reg,     n_lost_next;

    // Address arithmetic is done one bit wider so the wrap compare cannot overflow.
    logic [15:0] addr_inc16;
    logic [15:0] wptr_sum16;
    logic        full;
    logic        complete;
    logic        reject;
    logic        freed;

    assign addr_inc16 = {1'b0, waddr_reg} + 16'd1;
    assign wptr_sum16 = {1'b0, wptr_reg} + PKG_LEN16;
    // Fullness uses the current count; a read_done in this same cycle does not help.
    assign full       = (n_stored_reg >= MAX_PKG);
    // A read_done with nothing stored is ignored so the count never underflows.
    assign freed      = read_done && (n_stored_reg != 6'd0);

    // State, address and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            wen_reg        <= 1'b0;
            waddr_reg      <= 15'd0;
            cnt_reg        <= 12'd0;
            wptr_reg       <= 15'd0;
            read_start_reg <= 1'b0;
            n_stored_reg   <= 6'd0;
            n_lost_reg     <= 16'd0;
        end else begin
            state_reg      <= state_next;
            wen_reg        <= wen_next;
            waddr_reg      <= waddr_next;
            cnt_reg        <= cnt_next;
            wptr_reg       <= wptr_next;
            read_start_reg <= read_start_next;
            n_stored_reg   <= n_stored_next;
            n_lost_reg     <= n_lost_next;
        end
    end

    // Next-state logic: trigger acceptance, word streaming and package completion.
    always_comb begin
        state_next      = state_reg;
        wen_next        = wen_reg;
        waddr_next      = waddr_reg;
        cnt_next        = cnt_reg;
        wptr_next       = wptr_reg;
        read_start_next = 1'b0;
        complete        = 1'b0;
        reject          = 1'b0;

        if (live_rising) begin
            // Run-start clear wins over everything and drops any partial package.
            state_next = IDLE;
            wen_next   = 1'b0;
            waddr_next = 15'd0;
            cnt_next   = 12'd0;
            wptr_next  = 15'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        if (full) begin
                            reject = 1'b1;
                        end else begin
                            state_next = WRITE;
                            wen_next   = 1'b1;
                            waddr_next = wptr_reg;
                            cnt_next   = 12'd0;
                        end
                    end
                end
                WRITE: begin
                    // A trigger during a package is never queued.
                    if (trigger) begin
                        reject = 1'b1;
                    end
                    if (cnt_reg == LAST_CNT) begin
                        state_next      = IDLE;
                        wen_next        = 1'b0;
                        read_start_next = 1'b1;
                        complete        = 1'b1;
                        // Same start-address progression the read side uses.
                        wptr_next = (wptr_sum16 < DEPTH16) ? wptr_sum16[14:0]
                                                           : 15'(wptr_sum16 - DEPTH16);
                    end else begin
                        cnt_next   = cnt_reg + 12'd1;
                        waddr_next = (addr_inc16 >= DEPTH16) ? 15'd0 : addr_inc16[14:0];
                    end
                end
                default: begin
                    state_next = IDLE;
                    wen_next   = 1'b0;
                end
            endcase
        end
    end

    // Stored-package and lost-trigger counters.
    always_comb begin
        n_stored_next = n_stored_reg;
        n_lost_next   = n_lost_reg;
        if (live_rising) begin
            n_stored_next = 6'd0;
            n_lost_next   = 16'd0;
        end else begin
            if (complete && !freed) begin
                n_stored_next = n_stored_reg + 6'd1;
            end else if (!complete && freed) begin
                n_stored_next = n_stored_reg - 6'd1;
            end
            if (reject && (n_lost_reg != 16'hFFFF)) begin
                n_lost_next = n_lost_reg + 16'd1;
            end
        end
    end

    assign wen        = wen_reg;
    assign waddr      = waddr_reg;
    assign read_start = read_start_reg;
    assign busy       = (state_reg == WRITE);
    assign n_stored   = n_stored_reg;
    assign n_lost     = n_lost_reg;

endmodule

// File: tb/tb_write_control.sv
// Testbench for write_control: a package-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_write_control;

    localparam int PL    = 518;
    localparam int DEPTH = 24576;
    localparam int MAXP  = 47;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        live_rising = 1'b0;
    logic        trigger = 1'b0;
    logic        read_done = 1'b0;
    logic        wen;
    logic [14:0] waddr;
    logic        read_start;
    logic        busy;
    logic [5:0]  n_stored;
    logic [15:0] n_lost;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Per-cycle record of the most recent package run (index = cycle after trigger).
    int rec_addr [0:600];
    int rec_wen  [0:600];

    // Reference model: expected outputs for the current cycle.
    bit m_wen = 1'b0;
    int m_waddr = 0;
    bit m_rs = 1'b0;
    int m_stored = 0;
    int m_lost = 0;
    int m_wptr = 0;
    int m_start = 0;
    int m_idx = 0;
    bit m_finishing, m_accept, m_reject, m_freed;

    write_control #(
        .PACKAGE_LENGTH(PL),
        .MEMORY_DEPTH  (DEPTH),
        .MAX_PACKAGES  (MAXP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .live_rising(live_rising),
        .trigger    (trigger),
        .read_done  (read_done),
        .wen        (wen),
        .waddr      (waddr),
        .read_start (read_start),
        .busy       (busy),
        .n_stored   (n_stored),
        .n_lost     (n_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a package is a run of PL words starting at the stored-package
    // pointer; addresses are (start + index) mod DEPTH.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst || live_rising) begin
                m_wen = 0; m_waddr = 0; m_rs = 0; m_stored = 0;
                m_lost = 0; m_wptr = 0; m_start = 0; m_idx = 0;
            end else begin
                m_finishing = m_wen && (m_idx == PL - 1);
                m_accept    = !m_wen && trigger && (m_stored < MAXP);
                m_reject    = trigger && !m_accept;
                m_freed     = read_done && (m_stored > 0);
                m_stored    = m_stored + int'(m_finishing) - int'(m_freed);
                if (m_reject && m_lost < 65535) m_lost++;
                m_rs = m_finishing;
                if (m_finishing) begin
                    m_wen  = 0;
                    m_wptr = (m_wptr + PL) % DEPTH;
                end else if (m_wen) begin
                    m_idx++;
                    m_waddr = (m_start + m_idx) % DEPTH;
                end else if (m_accept) begin
                    m_wen   = 1;
                    m_idx   = 0;
                    m_start = m_wptr;
                    m_waddr = m_wptr;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("wen", int'(wen), int'(m_wen));
                if (m_wen) chk("waddr", int'(waddr), m_waddr);
                chk("read_start", int'(read_start), int'(m_rs));
                chk("busy", int'(busy), int'(m_wen));
                chk("n_stored", int'(n_stored), m_stored);
                chk("n_lost", int'(n_lost), m_lost);
            end
        end
    end

    // Issue a trigger now (caller is at a falling edge) and follow the package.
    // Optional injections happen at the given cycle numbers (-1 = none).
    // lat = cycles from trigger to read_start, or 0 if none within 600 cycles.
    task automatic run_package(input int trig_a, input int trig_b, input int trig_c,
                               input int rd_at, input int lr_at, output int lat);
        trigger = 1'b1;
        lat = 0;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            trigger     = 1'b0;
            read_done   = 1'b0;
            live_rising = 1'b0;
            rec_wen[n]  = int'(wen);
            rec_addr[n] = wen ? int'(waddr) : -1;
            if (read_start) begin
                lat = n;
                break;
            end
            if (n == trig_a || n == trig_b || n == trig_c) trigger = 1'b1;
            if (n == rd_at) read_done = 1'b1;
            if (n == lr_at) live_rising = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rs_seen;
        rs_seen = 0;
        for (int i = 0; i <= 600; i++) begin
            rec_addr[i] = -1;
            rec_wen[i]  = 0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_wen", int'(wen), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_read_start", int'(read_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_n_stored", int'(n_stored), 0);
        chk("rst_n_lost", int'(n_lost), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Single package from reset.
        run_package(-1, -1, -1, -1, -1, lat);
        if (lat == 519) rs_seen++;
        chk("t1_latency", lat, 519);
        chk("t1_first_wen", rec_wen[1], 1);
        chk("t1_first_addr", rec_addr[1], 0);
        chk("t1_last_addr", rec_addr[518], 517);
        chk("t1_n_stored", int'(n_stored), 1);
        $display("pkg 1 start=%0d latency=%0d n_stored=%0d", rec_addr[1], lat, n_stored);

        // Fill to capacity with back-to-back packages.
        for (int k = 1; k < MAXP; k++) begin
            run_package(-1, -1, -1, -1, -1, lat);
            if (lat == 519) rs_seen++;
            chk("fill_latency", lat, 519);
            if (k == 1) chk("fill_second_start", rec_addr[1], 518);
            if (k == MAXP - 1) begin
                chk("fill_last_start", rec_addr[1], 23828);
                chk("fill_last_end", rec_addr[518], 24345);
            end
            $display("pkg %0d start=%0d latency=%0d n_stored=%0d", k + 1, rec_addr[1], lat, n_stored);
        end
        chk("fill_read_starts", rs_seen, 47);
        chk("fill_n_stored", int'(n_stored), 47);

        // Trigger while full is rejected.
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        chk("full_no_wen", int'(wen), 0);
        chk("full_n_lost", int'(n_lost), 1);
        $display("trigger while full: wen=%0d n_lost=%0d", wen, n_lost);

        // One read_done, then a trigger one cycle later: accepted, wraps.
        read_done = 1'b1;
        @(negedge clk);
        read_done = 1'b0;
        run_package(-1, -1, -1, -1, -1, lat);
        chk("wrap_latency", lat, 519);
        chk("wrap_start", rec_addr[1], 24346);
        chk("wrap_top", rec_addr[230], 24575);
        chk("wrap_zero", rec_addr[231], 0);
        chk("wrap_end", rec_addr[518], 287);
        chk("wrap_n_stored", int'(n_stored), 47);
        $display("wrap pkg start=%0d end=%0d n_stored=%0d", rec_addr[1], rec_addr[518], n_stored);

        // read_done and trigger in the same cycle while full: trigger rejected.
        read_done = 1'b1;
        trigger   = 1'b1;
        @(negedge clk);
        read_done = 1'b0;
        trigger   = 1'b0;
        chk("same_cycle_no_wen", int'(wen), 0);
        chk("same_cycle_n_stored", int'(n_stored), 46);
        chk("same_cycle_n_lost", int'(n_lost), 2);
        $display("read_done+trigger while full: n_stored=%0d n_lost=%0d", n_stored, n_lost);

        // live_rising at write cycle 300 aborts the package.
        run_package(-1, -1, -1, -1, 301, lat);
        chk("abort_no_read_start", lat, 0);
        chk("abort_wen_before", rec_wen[301], 1);
        chk("abort_wen_after", rec_wen[302], 0);
        chk("abort_n_stored", int'(n_stored), 0);
        chk("abort_n_lost", int'(n_lost), 0);
        $display("live_rising abort: read_start_latency=%0d n_stored=%0d", lat, n_stored);

        // read_done with nothing stored is ignored.
        read_done = 1'b1;
        @(negedge clk);
        read_done = 1'b0;
        chk("underflow_n_stored", int'(n_stored), 0);

        // Triggers at write cycles 1, 200 and 517 are rejected without disturbance.
        run_package(2, 201, 518, -1, -1, lat);
        chk("busy_trig_latency", lat, 519);
        chk("busy_trig_start", rec_addr[1], 0);
        chk("busy_trig_mid", rec_addr[201], 200);
        chk("busy_trig_end", rec_addr[518], 517);
        chk("busy_trig_n_lost", int'(n_lost), 3);
        chk("busy_trig_n_stored", int'(n_stored), 1);
        $display("triggers while busy: n_lost=%0d n_stored=%0d", n_lost, n_stored);

        // Build to five stored, then complete with a coincident read_done.
        for (int k = 0; k < 4; k++) begin
            run_package(-1, -1, -1, -1, -1, lat);
            chk("build_latency", lat, 519);
            $display("pkg start=%0d latency=%0d n_stored=%0d", rec_addr[1], lat, n_stored);
        end
        chk("build_n_stored", int'(n_stored), 5);
        run_package(-1, -1, -1, 518, -1, lat);
        chk("coincide_latency", lat, 519);
        chk("coincide_n_stored", int'(n_stored), 5);
        $display("completion with read_done: n_stored=%0d", n_stored);

        // Asynchronous reset in the middle of a package.
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (100) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wen", int'(wen), 0);
        chk("arst_waddr", int'(waddr), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_read_start", int'(read_start), 0);
        chk("arst_n_stored", int'(n_stored), 0);
        chk("arst_n_lost", int'(n_lost), 0);
        $display("async reset mid-write: wen=%0d n_stored=%0d n_lost=%0d", wen, n_stored, n_lost);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_package(-1, -1, -1, -1, -1, lat);
        chk("post_rst_latency", lat, 519);
        chk("post_rst_start", rec_addr[1], 0);
        chk("post_rst_n_stored", int'(n_stored), 1);
        $display("pkg after reset start=%0d latency=%0d", rec_addr[1], lat);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
